// File: rtl/ram_port_arbiter.sv
// Shares one synchronous-read RAM between the processor port and the debug/loader port.
// Grant and RAM strobes are combinational in the request cycle; read data returns one cycle later.
// Losing requester waits holding its request; owner stickiness is capped by MAX_BURST to bound starvation.
module ram_port_arbiter #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  owner_t           owner;
  owner_t           last_owner;
  logic [CNT_W-1:0] burst_cnt;
  logic             win_cpu;
  logic             win_dbg;
  logic             cpu_rvalid_q;
  logic             dbg_rvalid_q;

  // Pick this cycle's winner; nothing is granted while reset is held.
  always_comb begin
    win_cpu = 1'b0;
    win_dbg = 1'b0;
    if (!rst) begin
      if (cpu_req && !dbg_req) begin
        win_cpu = 1'b1;
      end else if (dbg_req && !cpu_req) begin
        win_dbg = 1'b1;
      end else if (cpu_req && dbg_req) begin
        case (owner)
          OWN_CPU: begin
            win_cpu = (burst_cnt < MAX_CNT);
            win_dbg = !(burst_cnt < MAX_CNT);
          end
          OWN_DBG: begin
            win_dbg = (burst_cnt < MAX_CNT);
            win_cpu = !(burst_cnt < MAX_CNT);
          end
          default: begin
            // Fresh contention goes to whoever did not own the RAM most recently.
            win_cpu = (last_owner == OWN_DBG);
            win_dbg = (last_owner != OWN_DBG);
          end
        endcase
      end
    end
  end

  assign cpu_gnt   = win_cpu;
  assign dbg_gnt   = win_dbg;
  assign ram_addr  = win_cpu ? cpu_addr  : (win_dbg ? dbg_addr  : '0);
  assign ram_wdata = win_cpu ? cpu_wdata : (win_dbg ? dbg_wdata : '0);
  assign ram_we    = (win_cpu & cpu_we) | (win_dbg & dbg_we);

  // Ownership, burst counting and read-response tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner        <= OWN_IDLE;
      last_owner   <= OWN_DBG;
      burst_cnt    <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      cpu_rvalid_q <= win_cpu & ~cpu_we;
      dbg_rvalid_q <= win_dbg & ~dbg_we;
      if (!win_cpu && !win_dbg) begin
        owner     <= OWN_IDLE;
        burst_cnt <= '0;
      end else if ((win_cpu && owner == OWN_CPU) || (win_dbg && owner == OWN_DBG)) begin
        if (burst_cnt != MAX_CNT) begin
          burst_cnt <= burst_cnt + ONE_CNT;
        end
      end else begin
        owner      <= win_cpu ? OWN_CPU : OWN_DBG;
        last_owner <= win_cpu ? OWN_CPU : OWN_DBG;
        burst_cnt  <= ONE_CNT;
      end
    end
  end

  // A response whose cycle coincides with reset is dropped rather than delivered.
  assign cpu_rvalid = cpu_rvalid_q & ~rst;
  assign dbg_rvalid = dbg_rvalid_q & ~rst;
  assign cpu_rdata  = ram_rdata;
  assign dbg_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with an attached synchronous-read RAM.
// A history-based model predicts grants, RAM strobes and read responses every cycle.
// Directed scenarios with literal expectations run first, then randomized traffic with resets.
module tb_ram_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 16;
  localparam int MB = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // The RAM itself: synchronous read of the address presented last cycle.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: grant history since last reset (0 none, 1 cpu, 2 dbg).
  int            hist[$];
  int            last_win = 2;
  logic [DW-1:0] shadow [DEPTH];
  logic          exp_cpu_rv = 1'b0, exp_dbg_rv = 1'b0;
  logic [DW-1:0] exp_rd = '0;
  logic          chk_en = 1'b0;

  function automatic int run_len(input int who);
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != who || n >= MB) break;
      n++;
    end
    return n;
  endfunction

  function automatic int model_winner();
    int prev;
    if (rst) return 0;
    if (cpu_req && !dbg_req) return 1;
    if (dbg_req && !cpu_req) return 2;
    if (!cpu_req && !dbg_req) return 0;
    prev = (hist.size() > 0) ? hist[hist.size() - 1] : 0;
    if (prev == 0) return (last_win == 2) ? 1 : 2;
    if (run_len(prev) < MB) return prev;
    return 3 - prev;
  endfunction

  // Compare process: every cycle, check outputs against the model, then advance it.
  always @(negedge clk) begin
    int            ew;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    if (chk_en) begin
      ew      = model_winner();
      e_we    = (ew == 1) ? cpu_we : ((ew == 2) ? dbg_we : 1'b0);
      e_addr  = (ew == 1) ? cpu_addr : ((ew == 2) ? dbg_addr : '0);
      e_wdata = (ew == 1) ? cpu_wdata : ((ew == 2) ? dbg_wdata : '0);
      chk("cpu_gnt", 32'(cpu_gnt), 32'(ew == 1));
      chk("dbg_gnt", 32'(dbg_gnt), 32'(ew == 2));
      chk("ram_we", 32'(ram_we), 32'(e_we));
      if (!rst) begin
        chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
      end
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_cpu_rv & ~rst));
      chk("dbg_rvalid", 32'(dbg_rvalid), 32'(exp_dbg_rv & ~rst));
      if (exp_cpu_rv && !rst) chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_rd));
      if (exp_dbg_rv && !rst) chk("dbg_rdata", 32'(dbg_rdata), 32'(exp_rd));
      if (rst) begin
        hist.delete();
        last_win   = 2;
        exp_cpu_rv = 1'b0;
        exp_dbg_rv = 1'b0;
      end else begin
        hist.push_back(ew);
        while (hist.size() > 2 * MB) void'(hist.pop_front());
        if (ew != 0) last_win = ew;
        exp_cpu_rv = (ew == 1) && !e_we;
        exp_dbg_rv = (ew == 2) && !e_we;
        if (ew != 0 && !e_we) exp_rd = shadow[e_addr];
        if (ew != 0 && e_we) shadow[e_addr] = e_wdata;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic set_cpu(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dbg(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dbg_req = r; dbg_we = w; dbg_addr = a; dbg_wdata = d;
  endtask

  initial begin
    logic gc, gd;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]    = DW'($urandom);
      shadow[i] = mem[i];
    end
    mem[5]    = 16'h1234;
    shadow[5] = 16'h1234;

    // Reset state
    step();
    chk_en = 1'b1;
    neg();
    chk("reset cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("reset gnt", 32'({cpu_gnt, dbg_gnt, ram_we}), 32'd0);
    step(); rst = 1'b0;

    // Lone CPU read of address 5
    set_cpu(1, 0, 5'd5, '0);
    neg();
    chk("t1 cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("t1 ram_addr", 32'(ram_addr), 32'd5);
    step(); set_cpu(0, 0, '0, '0);
    neg();
    chk("t1 cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("t1 cpu_rdata", 32'(cpu_rdata), 32'h1234);

    // Both read right after reset: CPU first, then DBG
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    set_cpu(1, 0, 5'd7, '0); set_dbg(1, 0, 5'd9, '0);
    neg();
    chk("t2 first gnt", 32'({cpu_gnt, dbg_gnt}), 32'b10);
    step(); set_cpu(0, 0, '0, '0);
    neg();
    chk("t2 second gnt", 32'({cpu_gnt, dbg_gnt}), 32'b01);
    chk("t2 cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    step(); set_dbg(0, 0, '0, '0);
    neg();
    chk("t2 dbg_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'b01);

    // Continuous contention: CPU x4, DBG x4, ...
    step();
    set_cpu(1, 0, 5'd1, '0); set_dbg(1, 0, 5'd2, '0);
    for (int i = 0; i < 16; i++) begin
      neg();
      chk("t3 burst pattern", 32'({cpu_gnt, dbg_gnt}), ((i / 4) % 2 == 0) ? 32'b10 : 32'b01);
      step();
    end
    set_cpu(0, 0, '0, '0); set_dbg(0, 0, '0, '0);

    // DBG write then CPU read of the same address
    step(); set_dbg(1, 1, 5'd3, 16'hBEEF);
    neg();
    chk("t4 write we", 32'({ram_we, dbg_gnt}), 32'b11);
    step(); set_dbg(0, 0, '0, '0); set_cpu(1, 0, 5'd3, '0);
    neg();
    chk("t4 read we", 32'({ram_we, cpu_gnt}), 32'b01);
    step(); set_cpu(0, 0, '0, '0);
    neg();
    chk("t4 cpu_rdata", 32'(cpu_rdata), 32'hBEEF);

    // Reset right after a read grant drops the response
    step(); set_dbg(1, 0, 5'd4, '0);
    step(); set_dbg(0, 0, '0, '0); set_cpu(1, 0, 5'd6, '0);
    neg();
    chk("t5 cpu_gnt", 32'(cpu_gnt), 32'd1);
    step(); set_cpu(0, 0, '0, '0); rst = 1'b1;
    neg();
    chk("t5 dropped rvalid", 32'(cpu_rvalid), 32'd0);
    step(); rst = 1'b0;
    set_cpu(1, 0, 5'd8, '0); set_dbg(1, 0, 5'd10, '0);
    neg();
    chk("t5 tie after reset", 32'({cpu_gnt, dbg_gnt}), 32'b10);
    step(); set_cpu(0, 0, '0, '0); set_dbg(0, 0, '0, '0);

    // DBG alone for 10 cycles: no burst limit applies
    for (int i = 0; i < 10; i++) begin
      set_dbg(1, 1'($urandom), 5'($urandom), 16'($urandom));
      neg();
      chk("t6 dbg only", 32'({cpu_gnt, dbg_gnt}), 32'b01);
      step();
    end
    set_dbg(0, 0, '0, '0);

    // Randomized traffic: requests held until granted, occasional drops and resets
    for (int c = 0; c < 4000; c++) begin
      neg();
      gc = cpu_gnt;
      gd = dbg_gnt;
      step();
      rst = ($urandom_range(0, 79) == 0);
      if (cpu_req && !gc) begin
        if ($urandom_range(0, 15) == 0) set_cpu(0, 0, '0, '0);
      end else begin
        if ($urandom_range(0, 9) < 7) set_cpu(1, 1'($urandom), 5'($urandom), 16'($urandom));
        else set_cpu(0, 0, '0, '0);
      end
      if (dbg_req && !gd) begin
        if ($urandom_range(0, 15) == 0) set_dbg(0, 0, '0, '0);
      end else begin
        if ($urandom_range(0, 9) < 7) set_dbg(1, 1'($urandom), 5'($urandom), 16'($urandom));
        else set_dbg(0, 0, '0, '0);
      end
    end
    neg();
    step();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
